// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer and its flag register:
//   - ALU opcode encodings (OP_*)
//   - bit positions of the NZCV flags inside a 4-bit flag word (FLG_*)
//   - sequencer FSM state type
//   - isKnownOp(): true for opcodes the ALU actually implements
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seqState_t;

    function automatic logic isKnownOp(input logic [1:0] op);
        case (op)
            OP_ADD, OP_MUL, OP_DIV: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage : alu_pkg

// File: rtl/alu_flag_reg.sv
// -----------------------------------------------------------------------------
// alu_flag_reg
// 4-bit sticky NZCV status register. A capture ORs new flags into the stored
// value; a clear zeroes it. When both happen in the same cycle the clear is
// applied first, so the register ends up holding exactly the new flags.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   clr       in   clear the sticky value
//   capture   in   merge newFlags into the sticky value
//   newFlags  in   [3:0] flags from the current ALU result
//   flags     out  [3:0] sticky value
// -----------------------------------------------------------------------------
module alu_flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       capture,
    input  logic [3:0] newFlags,
    output logic [3:0] flags
);

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples its inputs from the same pre-edge values, whatever the order of
    // statements in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (capture) begin
            flags <= (clr ? 4'b0000 : flags) | newFlags;
        end else if (clr) begin
            flags <= 4'b0000;
        end
    end

endmodule : alu_flag_reg

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command-side master for a combinational ALU. A command (operands, opcode,
// carry-in) accepted on the cmd valid/ready channel is registered onto the ALU
// operand ports, allowed to settle for EXEC_CYCLES cycles, and the ALU result
// and flags are then captured and returned on the rsp valid/ready channel.
// Reserved opcodes and divide-by-zero produce an error response with zero
// data/flags. Valid results are merged into a sticky NZCV status register.
//
// Parameters:
//   WIDTH        MSB index of data words (data width WIDTH+1)
//   EXEC_CYCLES  cycles between driving the ALU and capturing it (>=1)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_a, cmd_b, cmd_op, cmd_ci command payload
//   alu_a, alu_b, alu_opCode, alu_ci  registered ALU inputs
//   alu_out, alu_co, alu_negativo, alu_cero, alu_acarreo,
//   alu_desbordamiento          ALU result and flags (alu_co not used)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_flags, rsp_err response payload ({N,Z,C,V} in rsp_flags)
//   flags_q, flags_clr          sticky status register and its clear
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH:0]   cmd_a,
    input  logic [WIDTH:0]   cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_ci,

    output logic [WIDTH:0]   alu_a,
    output logic [WIDTH:0]   alu_b,
    output logic [1:0]       alu_opCode,
    output logic             alu_ci,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_co,
    input  logic             alu_negativo,
    input  logic             alu_cero,
    input  logic             alu_acarreo,
    input  logic             alu_desbordamiento,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,

    output logic [3:0]       flags_q,
    input  logic             flags_clr
);

    localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    seqState_t        state;
    logic [CNT_W-1:0] waitCnt;
    logic             captureNow;
    logic             divByZero;
    logic             flagCapture;
    logic [3:0]       newFlags;
    logic             unusedCo;

    // Carry-out is reported through alu_acarreo; the raw carry is not stored.
    assign unusedCo = alu_co;

    assign cmd_ready   = (state == IDLE) && !rst;
    assign captureNow  = (state == EXEC) && (waitCnt == '0);
    // Judged on the registered ALU inputs, i.e. the command being executed.
    assign divByZero   = (alu_opCode == OP_DIV) && (alu_b == '0);
    assign flagCapture = captureNow && !divByZero;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        newFlags        = 4'b0000;
        newFlags[FLG_N] = alu_negativo;
        newFlags[FLG_Z] = alu_cero;
        newFlags[FLG_C] = alu_acarreo;
        newFlags[FLG_V] = alu_desbordamiento;
    end

    alu_flag_reg uFlagReg (
        .clk      (clk),
        .rst      (rst),
        .clr      (flags_clr),
        .capture  (flagCapture),
        .newFlags (newFlags),
        .flags    (flags_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register here is a plain control/datapath flop (no
            // memory array), so all of them are reset; an in-flight command is
            // simply dropped.
            state      <= IDLE;
            waitCnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opCode <= OP_ADD;
            alu_ci     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= 4'b0000;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!isKnownOp(cmd_op)) begin
                            // Nothing to execute: answer at once and leave
                            // the ALU inputs on the previous command.
                            rsp_data  <= '0;
                            rsp_flags <= 4'b0000;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a      <= cmd_a;
                            alu_b      <= cmd_b;
                            alu_opCode <= cmd_op;
                            alu_ci     <= cmd_ci;
                            waitCnt    <= CNT_LOAD;
                            state      <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    if (waitCnt == '0) begin
                        if (divByZero) begin
                            rsp_data  <= '0;
                            rsp_flags <= 4'b0000;
                            rsp_err   <= 1'b1;
                        end else begin
                            rsp_data  <= alu_out;
                            rsp_flags <= newFlags;
                            rsp_err   <= 1'b0;
                        end
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : alu_cmd_sequencer

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer (WIDTH=3, EXEC_CYCLES=2). A small
// behavioural ALU with one cycle of output lag stands in for the real ALU.
// Stimulus pushes the predicted response into a queue; an independent monitor
// pops and compares whenever a response appears.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int WIDTH       = 3;
    localparam int EXEC_CYCLES = 2;
    localparam int W           = WIDTH + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic [1:0]     cmd_op;
    logic           cmd_ci;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [1:0]     alu_opCode;
    logic           alu_ci;
    logic [W-1:0]   alu_out;
    logic           alu_co;
    logic           alu_negativo;
    logic           alu_cero;
    logic           alu_acarreo;
    logic           alu_desbordamiento;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [3:0]     rsp_flags;
    logic           rsp_err;
    logic [3:0]     flags_q;
    logic           flags_clr;

    alu_cmd_sequencer #(
        .WIDTH       (WIDTH),
        .EXEC_CYCLES (EXEC_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_a              (cmd_a),
        .cmd_b              (cmd_b),
        .cmd_op             (cmd_op),
        .cmd_ci             (cmd_ci),
        .alu_a              (alu_a),
        .alu_b              (alu_b),
        .alu_opCode         (alu_opCode),
        .alu_ci             (alu_ci),
        .alu_out            (alu_out),
        .alu_co             (alu_co),
        .alu_negativo       (alu_negativo),
        .alu_cero           (alu_cero),
        .alu_acarreo        (alu_acarreo),
        .alu_desbordamiento (alu_desbordamiento),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data),
        .rsp_flags          (rsp_flags),
        .rsp_err            (rsp_err),
        .flags_q            (flags_q),
        .flags_clr          (flags_clr)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ---------------- behavioural ALU ----------------
    typedef struct packed {
        logic [W-1:0] out;
        logic         co;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } aluRaw_t;

    function automatic aluRaw_t aluFn(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op, input logic ci);
        aluRaw_t r;
        int ai, bi, res;
        r  = '0;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00: begin
                res   = ai + bi + int'(ci);
                r.out = W'(res);
                r.c   = (res >= (1 << W));
                r.co  = r.c;
                r.v   = (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
            end
            2'b01: begin
                res   = ai * bi;
                r.out = W'(res);
                r.c   = (res >= (1 << W));
                r.v   = r.c;
            end
            2'b10: begin
                if (bi != 0) r.out = W'(ai / bi);
            end
            default: r.out = '0;
        endcase
        r.n = r.out[W-1];
        r.z = (r.out == '0);
        // Garbage the sequencer must not pass through on divide-by-zero.
        if (op == 2'b10 && bi == 0) begin
            r.out = '1;
            r   = '{out: '1, co: 1'b1, n: 1'b1, z: 1'b0, c: 1'b1, v: 1'b1};
        end
        return r;
    endfunction

    // One cycle of lag stands in for the multiplier/divider settle time.
    aluRaw_t aluRes = '0;
    always @(posedge clk) aluRes <= aluFn(alu_a, alu_b, alu_opCode, alu_ci);
    assign alu_out            = aluRes.out;
    assign alu_co             = aluRes.co;
    assign alu_negativo       = aluRes.n;
    assign alu_cero           = aluRes.z;
    assign alu_acarreo        = aluRes.c;
    assign alu_desbordamiento = aluRes.v;

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   flags;
        logic         err;
        logic [3:0]   flagsQ;
        logic [W-1:0] aluA;
        logic [W-1:0] aluB;
        logic [1:0]   aluOp;
        logic         aluCi;
        int           lat;
        int           issue;
    } expItem_t;

    expItem_t     expQ[$];
    logic [3:0]   modelFlags = 4'b0000;
    logic [W-1:0] lastA = '0;
    logic [W-1:0] lastB = '0;
    logic [1:0]   lastOp = 2'b00;
    logic         lastCi = 1'b0;

    int numCompared   = 0;
    int numMismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        numCompared++;
        if (act !== expv) begin
            numMismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic expItem_t predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op, input logic ci,
                                         input bit clrAtCapture);
        expItem_t e;
        aluRaw_t  r;
        e = '{default: '0};
        if (op == 2'b11) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            lastA  = a;
            lastB  = b;
            lastOp = op;
            lastCi = ci;
            e.lat  = EXEC_CYCLES + 1;
            if (op == 2'b10 && b == '0) begin
                e.err = 1'b1;
            end else begin
                r          = aluFn(a, b, op, ci);
                e.data     = r.out;
                e.flags    = {r.n, r.z, r.c, r.v};
                modelFlags = (clrAtCapture ? 4'b0000 : modelFlags) | e.flags;
            end
        end
        e.flagsQ = modelFlags;
        e.aluA   = lastA;
        e.aluB   = lastB;
        e.aluOp  = lastOp;
        e.aluCi  = lastCi;
        return e;
    endfunction

    // Call at a negative edge; returns at a negative edge after acceptance.
    task automatic sendCmd(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic ci, input bit clrAtCapture);
        expItem_t e;
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            numCompared++;
            numMismatched++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b, expected 1", cmd_ready);
            return;
        end
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_ci    = ci;
        cmd_valid = 1'b1;
        e         = predict(a, b, op, ci, clrAtCapture);
        e.issue   = cycleCnt;
        expQ.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (clrAtCapture) begin
            @(negedge clk);
            flags_clr = 1'b1;
            @(negedge clk);
            flags_clr = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || rsp_valid || !cmd_ready) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("drain_queue", expQ.size(), 0);
    endtask

    // ---------------- response-ready driver ----------------
    int readyMode = 0;  // 0: always ready, 1: random, 2: held low
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        expItem_t cur;
        bit inResp;
        bit justHs;
        inResp = 1'b0;
        justHs = 1'b0;
        cur    = '{default: '0};
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                inResp = 1'b0;
                justHs = 1'b0;
            end else if (justHs) begin
                check("valid_fall_after_hs", rsp_valid, 0);
                check("ready_after_hs", cmd_ready, 1);
                justHs = 1'b0;
            end else if (rsp_valid) begin
                check("cmd_ready_busy", cmd_ready, 0);
                if (!inResp) begin
                    if (expQ.size() == 0) begin
                        numCompared++;
                        numMismatched++;
                        $display("FAIL unexpected_rsp: data %0h err %0b, expected no response",
                                 rsp_data, rsp_err);
                    end else begin
                        cur = expQ.pop_front();
                        check("latency", cycleCnt - cur.issue, cur.lat);
                        check("rsp_data", rsp_data, cur.data);
                        check("rsp_flags", rsp_flags, cur.flags);
                        check("rsp_err", rsp_err, cur.err);
                        check("flags_q", flags_q, cur.flagsQ);
                        check("alu_a", alu_a, cur.aluA);
                        check("alu_b", alu_b, cur.aluB);
                        check("alu_opCode", alu_opCode, cur.aluOp);
                        check("alu_ci", alu_ci, cur.aluCi);
                    end
                    inResp = 1'b1;
                end else begin
                    check("stable_data", rsp_data, cur.data);
                    check("stable_flags", rsp_flags, cur.flags);
                    check("stable_err", rsp_err, cur.err);
                end
                if (rsp_ready) begin
                    justHs = 1'b1;
                    inResp = 1'b0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   rop;
        int           guard;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = 2'b00;
        cmd_ci    = 1'b0;
        flags_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_opCode", alu_opCode, 0);
        check("rst_alu_ci", alu_ci, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_flags_q", flags_q, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // Add with carry-out and zero result, then mul, div-by-zero, reserved.
        sendCmd(4'd7, 4'd9, 2'b00, 1'b0, 1'b0);
        check("alu_a_next_cycle", alu_a, 7);
        sendCmd(4'd3, 4'd2, 2'b01, 1'b0, 1'b0);
        sendCmd(4'd5, 4'd0, 2'b10, 1'b0, 1'b0);
        sendCmd(4'd6, 4'd1, 2'b11, 1'b1, 1'b0);
        waitIdle();

        // Backpressure: response held, stray command ignored.
        readyMode = 2;
        sendCmd(4'd12, 4'd3, 2'b10, 1'b0, 1'b0);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cmd_a     = 4'd1;
            cmd_b     = 4'd1;
            cmd_op    = 2'b00;
            cmd_valid = (i == 2);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        readyMode = 0;
        waitIdle();

        // Reset in the middle of EXEC drops the command and the status.
        sendCmd(4'd1, 4'd2, 2'b00, 1'b0, 1'b0);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_a     = 4'd9;
        cmd_b     = 4'd9;
        cmd_op    = 2'b01;
        expQ.delete();
        modelFlags = 4'b0000;
        lastA  = '0;
        lastB  = '0;
        lastOp = 2'b00;
        lastCi = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_flags_q", flags_q, 0);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("postrst_cmd_ready", cmd_ready, 1);
        repeat (6) @(negedge clk);

        // Clear alone, then clear coincident with a capture.
        sendCmd(4'd4, 4'd4, 2'b00, 1'b0, 1'b0);
        waitIdle();
        flags_clr  = 1'b1;
        modelFlags = 4'b0000;
        @(negedge clk);
        flags_clr = 1'b0;
        check("clr_alone", flags_q, 0);
        sendCmd(4'd4, 4'd4, 2'b00, 1'b0, 1'b0);
        sendCmd(4'd7, 4'd9, 2'b00, 1'b0, 1'b1);
        waitIdle();
        check("clr_with_capture", flags_q, 4'b0110);

        // Randomized traffic with random response backpressure.
        readyMode = 1;
        for (int i = 0; i < 80; i++) begin
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            rop = 2'($urandom_range(0, 3));
            sendCmd(ra, rb, rop, 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        readyMode = 0;
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
